// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Central hazard detection and forwarding control for the 5-stage MIPS core
// (IF/ID/EX/MEM/WB). It sits beside the main controller. It drives the pipeline
// register enables, the bubble selects and the operand forwarding muxes of the
// datapath. Every decision is combinational and is made in the same cycle. The
// only state is the multiply stall counter and the stall-cycle counter.
//
// Parameters
//   REG_ADDR_W   register specifier width; register 0 is never a hazard source
//   MUL_LATENCY  EX cycles of a multiply (>=1); the pipeline freezes for
//                MUL_LATENCY-1 cycles after the multiply enters EX
//   FWD_ENABLE   1: EX and ID forwarding active
//                0: forwards held at 0, and any RAW against an EX/MEM writer
//                   stalls instead
//   STALL_CNT_W  width of stall_cycles
//
// Ports
//   clk, rst                    rising-edge clock, asynchronous active-low reset
//   id_rs, id_rt                source registers of the instruction in ID
//   id_uses_rs, id_uses_rt      ID instruction really reads rs / rt
//   id_branch, id_taken         beq/bne in ID, and its comparator result
//   id_jump                     j/jal in ID
//   ex_rs, ex_rt, ex_rd         ID/EX sources and destination (after RegDst)
//   ex_reg_write, ex_mem_read   ID/EX write-back and load controls
//   ex_mul_start                one-cycle pulse: a multiply is entering EX
//   mem_rd, mem_reg_write,      EX/MEM destination and controls
//   mem_mem_read
//   wb_rd, wb_reg_write         MEM/WB destination and control
//   stall_clr                   synchronous clear of stall_cycles
//   pc_write, if_id_write       PC and IF/ID enables
//   if_flush, pc_src            zero IF/ID instruction; select branch/jump target
//   id_ex_bubble                NOP controls into ID/EX
//   ex_hold, mem_bubble         freeze ID/EX + EX/MEM; NOP controls into MEM/WB
//   forward_a, forward_b        EX operand mux: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_id_a, fwd_id_b          ID comparator operand from the EX/MEM ALU result
//   mul_busy                    multiply freeze in progress
//   stall_cycles                saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 4,
  parameter bit FWD_ENABLE  = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_branch,
  input  logic                   id_taken,
  input  logic                   id_jump,
  input  logic [REG_ADDR_W-1:0]  ex_rs,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_mul_start,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic                   mem_reg_write,
  input  logic                   mem_mem_read,
  input  logic [REG_ADDR_W-1:0]  wb_rd,
  input  logic                   wb_reg_write,
  input  logic                   stall_clr,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_flush,
  output logic                   pc_src,
  output logic                   id_ex_bubble,
  output logic                   ex_hold,
  output logic                   mem_bubble,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   fwd_id_a,
  output logic                   fwd_id_b,
  output logic                   mul_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Counter wide enough to hold MUL_LATENCY-1. It is at least 1 bit, so
  // MUL_LATENCY=1 still builds. In that case it simply never leaves 0.
  localparam int MUL_CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LATENCY - 1);

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // One winner per cycle, in priority order mul > data stall > redirect.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_MUL,
    ACT_STALL,
    ACT_REDIRECT,
    ACT_RUN
  } action_e;

  action_e action;

  logic [MUL_CNT_W-1:0] mul_cnt;
  logic                 mul_active;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic match(input logic [REG_ADDR_W-1:0] x,
                                 input logic [REG_ADDR_W-1:0] r);
    return (x != '0) && (x == r);
  endfunction

  // ---------------------------------------------------------------------------
  // Dependency terms between the ID instruction's used sources and writers
  // ---------------------------------------------------------------------------
  logic id_dep_ex;   // ID source produced by the instruction in EX
  logic id_dep_mem;  // ID source produced by the instruction in MEM
  logic load_use;
  logic branch_hazard;
  logic nofwd_hazard;
  logic data_stall;
  logic redirect;

  always_comb begin
    id_dep_ex  = (id_uses_rs && match(ex_rd, id_rs)) ||
                 (id_uses_rt && match(ex_rd, id_rt));
    id_dep_mem = (id_uses_rs && match(mem_rd, id_rs)) ||
                 (id_uses_rt && match(mem_rd, id_rt));

    load_use = ex_mem_read && id_dep_ex;

    // The branch compares in ID, so it cannot see a value still being computed
    // in EX. It also cannot see load data that is still in MEM. A load ahead of
    // a branch therefore stalls twice: once in EX and once in MEM. An ALU op
    // ahead of a branch stalls once, and is then forwarded from EX/MEM.
    branch_hazard = id_branch &&
                    ((ex_reg_write && id_dep_ex) ||
                     (mem_mem_read && id_dep_mem));

    // Without forwarding, every in-flight producer stalls. WB never stalls,
    // because the register file writes in the first half-cycle.
    nofwd_hazard = !FWD_ENABLE &&
                   ((ex_reg_write && id_dep_ex) ||
                    (mem_reg_write && id_dep_mem));

    data_stall = load_use || branch_hazard || nofwd_hazard;
    redirect   = (id_branch && id_taken) || id_jump;
  end

  assign mul_active = (mul_cnt != '0);

  // ---------------------------------------------------------------------------
  // Action select and pipeline control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    action = ACT_RUN;
    if (!rst) begin
      action = ACT_RESET;
    end else if (mul_active) begin
      action = ACT_MUL;
    end else if (data_stall) begin
      action = ACT_STALL;
    end else if (redirect) begin
      action = ACT_REDIRECT;
    end
  end

  // NOTE: every output gets a default before the case, so no path through this
  // block can leave a signal unassigned and infer a latch.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    pc_src       = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    mem_bubble   = 1'b0;
    mul_busy     = 1'b0;
    unique case (action)
      ACT_RESET: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      ACT_MUL: begin
        // The whole front end freezes with the multiply held in EX. Nothing
        // retires into MEM/WB until the multiply is done.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_hold     = 1'b1;
        mem_bubble  = 1'b1;
        mul_busy    = 1'b1;
      end
      ACT_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      ACT_REDIRECT: begin
        if_flush = 1'b1;
        pc_src   = 1'b1;
      end
      ACT_RUN: begin
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Forwarding muxes (EX operands and ID branch comparator)
  // ---------------------------------------------------------------------------
  always_comb begin
    forward_a = FWD_REG;
    forward_b = FWD_REG;
    fwd_id_a  = 1'b0;
    fwd_id_b  = 1'b0;
    if (FWD_ENABLE && rst) begin
      // EX/MEM holds the younger result, so it takes priority over MEM/WB.
      if (mem_reg_write && match(mem_rd, ex_rs)) begin
        forward_a = FWD_MEM;
      end else if (wb_reg_write && match(wb_rd, ex_rs)) begin
        forward_a = FWD_WB;
      end
      if (mem_reg_write && match(mem_rd, ex_rt)) begin
        forward_b = FWD_MEM;
      end else if (wb_reg_write && match(wb_rd, ex_rt)) begin
        forward_b = FWD_WB;
      end
      // Only an ALU result exists in EX/MEM. Load data is not ready until WB,
      // so a load in MEM is covered by the branch stall instead.
      fwd_id_a = id_branch && mem_reg_write && !mem_mem_read &&
                 match(mem_rd, id_rs);
      fwd_id_b = id_branch && mem_reg_write && !mem_mem_read &&
                 match(mem_rd, id_rt);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiply stall counter
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_cnt <= '0;
    end else if (mul_active) begin
      mul_cnt <= mul_cnt - 1'b1;
    end else if (ex_mul_start) begin
      mul_cnt <= MUL_LOAD;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle performance counter (saturating, clear wins)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_unit
//
// Two instances share one set of inputs:
//   dut_a: default parameters (forwarding on, MUL_LATENCY=4, 16-bit counter)
//   dut_b: FWD_ENABLE=0 and STALL_CNT_W=4 (no-forward stalls and saturation)
//
// Each directed cycle gives, for each instance, the expected action (run,
// stall, mul freeze, redirect, reset) and the expected forward selects. The
// action and selects are expanded into a control word, and a stall-count model
// tracks the counters. The expectation is pushed into a scoreboard. A monitor
// on the falling edge pops each entry and compares it with both DUTs.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

  typedef enum int {K_RESET, K_RUN, K_STALL, K_MUL, K_REDIR} kind_e;

  typedef struct {
    string       name;
    logic [13:0] ctl_a;
    logic [13:0] ctl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_branch, id_taken, id_jump;
  logic       ex_reg_write, ex_mem_read, ex_mul_start;
  logic       mem_reg_write, mem_mem_read, wb_reg_write, stall_clr;

  logic        pc_write_a, if_id_write_a, if_flush_a, pc_src_a, id_ex_bubble_a;
  logic        ex_hold_a, mem_bubble_a, fwd_id_a_a, fwd_id_b_a, mul_busy_a;
  logic [1:0]  forward_a_a, forward_b_a;
  logic [15:0] stall_cycles_a;

  logic        pc_write_b, if_id_write_b, if_flush_b, pc_src_b, id_ex_bubble_b;
  logic        ex_hold_b, mem_bubble_b, fwd_id_a_b, fwd_id_b_b, mul_busy_b;
  logic [1:0]  forward_a_b, forward_b_b;
  logic [3:0]  stall_cycles_b;

  logic [13:0] ctl_a, ctl_b;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cnt_a_model = 0;
  int   cnt_b_model = 0;

  pipeline_hazard_unit dut_a (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_taken(id_taken), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall_clr(stall_clr),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_flush(if_flush_a),
    .pc_src(pc_src_a), .id_ex_bubble(id_ex_bubble_a), .ex_hold(ex_hold_a),
    .mem_bubble(mem_bubble_a), .forward_a(forward_a_a), .forward_b(forward_b_a),
    .fwd_id_a(fwd_id_a_a), .fwd_id_b(fwd_id_b_a), .mul_busy(mul_busy_a),
    .stall_cycles(stall_cycles_a)
  );

  pipeline_hazard_unit #(.FWD_ENABLE(1'b0), .STALL_CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_taken(id_taken), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mul_start(ex_mul_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .stall_clr(stall_clr),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_flush(if_flush_b),
    .pc_src(pc_src_b), .id_ex_bubble(id_ex_bubble_b), .ex_hold(ex_hold_b),
    .mem_bubble(mem_bubble_b), .forward_a(forward_a_b), .forward_b(forward_b_b),
    .fwd_id_a(fwd_id_a_b), .fwd_id_b(fwd_id_b_b), .mul_busy(mul_busy_b),
    .stall_cycles(stall_cycles_b)
  );

  assign ctl_a = {pc_write_a, if_id_write_a, if_flush_a, pc_src_a, id_ex_bubble_a,
                  ex_hold_a, mem_bubble_a, forward_a_a, forward_b_a,
                  fwd_id_a_a, fwd_id_b_a, mul_busy_a};
  assign ctl_b = {pc_write_b, if_id_write_b, if_flush_b, pc_src_b, id_ex_bubble_b,
                  ex_hold_b, mem_bubble_b, forward_a_b, forward_b_b,
                  fwd_id_a_b, fwd_id_b_b, mul_busy_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: the stimulus never waits on the DUT, but the run must still end.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Expand an expected action and forward selects into the packed control
  // word, in the same bit order as ctl_a / ctl_b.
  function automatic logic [13:0] make_ctl(input kind_e k, input logic [1:0] fa,
                                           input logic [1:0] fb, input logic fia,
                                           input logic fib);
    logic pcw, ifw, fl, ps, bub, hold, mb, busy;
    logic [1:0] a, b;
    logic ia, ib;
    pcw = 1'b0; ifw = 1'b0; fl = 1'b0; ps = 1'b0;
    bub = 1'b0; hold = 1'b0; mb = 1'b0; busy = 1'b0;
    a = fa; b = fb; ia = fia; ib = fib;
    case (k)
      K_RESET: begin bub = 1'b1; a = 2'b00; b = 2'b00; ia = 1'b0; ib = 1'b0; end
      K_RUN:   begin pcw = 1'b1; ifw = 1'b1; end
      K_STALL: begin bub = 1'b1; end
      K_MUL:   begin hold = 1'b1; mb = 1'b1; busy = 1'b1; end
      K_REDIR: begin pcw = 1'b1; ifw = 1'b1; fl = 1'b1; ps = 1'b1; end
      default: begin end
    endcase
    return {pcw, ifw, fl, ps, bub, hold, mb, a, b, ia, ib, busy};
  endfunction

  function automatic int next_cnt(input int cur, input kind_e k, input int max_val);
    if (stall_clr) return 0;
    if ((k == K_STALL || k == K_MUL) && cur < max_val) return cur + 1;
    return cur;
  endfunction

  // Issue one cycle. The inputs are already driven (at posedge+1). B's
  // forwards are always expected 0.
  task automatic cyc(input string name, input kind_e ka, input kind_e kb,
                     input logic [1:0] fa = 2'b00, input logic [1:0] fb = 2'b00,
                     input logic fia = 1'b0, input logic fib = 1'b0);
    exp_t e;
    if (!rst) begin
      cnt_a_model = 0;
      cnt_b_model = 0;
    end
    e.name  = name;
    e.ctl_a = make_ctl(ka, fa, fb, fia, fib);
    e.ctl_b = make_ctl(kb, 2'b00, 2'b00, 1'b0, 1'b0);
    e.cnt_a = 16'(cnt_a_model);
    e.cnt_b = 4'(cnt_b_model);
    sb.push_back(e);
    if (rst) begin
      cnt_a_model = next_cnt(cnt_a_model, ka, 65535);
      cnt_b_model = next_cnt(cnt_b_model, kb, 15);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_taken = 1'b0; id_jump = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mul_start = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0; stall_clr = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic ut, input logic br, input logic tk, input logic jp);
    id_rs = rs; id_rt = rt; id_uses_rs = ur; id_uses_rt = ut;
    id_branch = br; id_taken = tk; id_jump = jp;
  endtask

  task automatic set_ex(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic ms);
    ex_rs = rs; ex_rt = rt; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mul_start = ms;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic rw, input logic mr);
    mem_rd = rd; mem_reg_write = rw; mem_mem_read = mr;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic rw);
    wb_rd = rd; wb_reg_write = rw;
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, ".ctl_a"}, 32'(ctl_a), 32'(e.ctl_a));
      check({e.name, ".ctl_b"}, 32'(ctl_b), 32'(e.ctl_b));
      check({e.name, ".cnt_a"}, 32'(stall_cycles_a), 32'(e.cnt_a));
      check({e.name, ".cnt_b"}, 32'(stall_cycles_b), 32'(e.cnt_b));
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state; pending hazards and forwards are masked while in reset.
    cyc("reset0", K_RESET, K_RESET);
    set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    set_ex(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1);
    set_mem(5'd2, 1'b1, 1'b0);
    cyc("reset1", K_RESET, K_RESET);
    rst = 1'b1;
    idle_inputs();
    cyc("idle", K_RUN, K_RUN);

    // lw $2,0($1); add $3,$2,$4
    set_id(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);
    cyc("lu_stall", K_STALL, K_STALL);
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_mem(5'd2, 1'b1, 1'b1);
    cyc("lu_resume", K_RUN, K_STALL);
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0);
    set_mem(5'd0, 1'b0, 1'b0);
    set_wb(5'd2, 1'b1);
    cyc("lu_fwd_wb", K_RUN, K_RUN, 2'b01, 2'b00);

    // add $2; sub $5,$2,$2 (MEM beats WB), then $0 and mixed cases.
    set_ex(5'd2, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    set_mem(5'd2, 1'b1, 1'b0);
    set_wb(5'd2, 1'b1);
    cyc("fwd_mem_both", K_RUN, K_RUN, 2'b10, 2'b10);
    set_ex(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_mem(5'd0, 1'b1, 1'b0);
    set_wb(5'd0, 1'b1);
    cyc("fwd_r0", K_RUN, K_RUN, 2'b00, 2'b00);
    set_ex(5'd7, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    set_mem(5'd7, 1'b1, 1'b0);
    set_wb(5'd2, 1'b1);
    cyc("fwd_mem_a_wb_b", K_RUN, K_RUN, 2'b10, 2'b01);
    set_ex(5'd2, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0);
    set_mem(5'd2, 1'b0, 1'b0);
    set_wb(5'd2, 1'b1);
    cyc("fwd_mem_nowrite", K_RUN, K_RUN, 2'b01, 2'b00);

    // Multiply: freeze exactly MUL_LATENCY-1 = 3 cycles. A jump during the
    // freeze is not taken, and a second start during the freeze is ignored.
    idle_inputs();
    ex_mul_start = 1'b1;
    cyc("mul_start", K_RUN, K_RUN);
    idle_inputs();
    id_jump = 1'b1;
    cyc("mul_busy1_jump", K_MUL, K_MUL);
    idle_inputs();
    ex_mul_start = 1'b1;
    cyc("mul_busy2_restart", K_MUL, K_MUL);
    idle_inputs();
    cyc("mul_busy3", K_MUL, K_MUL);
    cyc("mul_done", K_RUN, K_RUN);

    // lw $1; beq $1,$2 -> two stalls, then taken from the regfile.
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ex(5'd3, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0);
    cyc("lbr_stall_ex", K_STALL, K_STALL);
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_mem(5'd1, 1'b1, 1'b1);
    cyc("lbr_stall_mem", K_STALL, K_STALL);
    set_mem(5'd0, 1'b0, 1'b0);
    set_wb(5'd1, 1'b1);
    id_taken = 1'b1;
    cyc("lbr_taken", K_REDIR, K_REDIR);

    // add $1; beq $1,$2 -> one stall, then ID forward and redirect.
    idle_inputs();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    set_ex(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc("abr_stall", K_STALL, K_STALL);
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_mem(5'd1, 1'b1, 1'b0);
    id_taken = 1'b1;
    cyc("abr_fwd_taken", K_REDIR, K_STALL, 2'b00, 2'b00, 1'b1, 1'b0);
    id_taken = 1'b0;
    set_mem(5'd2, 1'b1, 1'b0);
    cyc("abr_fwd_b", K_RUN, K_STALL, 2'b00, 2'b00, 1'b0, 1'b1);
    idle_inputs();
    id_jump = 1'b1;
    cyc("jump", K_REDIR, K_REDIR);

    // add $2; add $3,$2,$2 -> B stalls for 2 cycles; A forwards instead.
    idle_inputs();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    cyc("nofwd_ex", K_RUN, K_STALL);
    set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_mem(5'd2, 1'b1, 1'b0);
    cyc("nofwd_mem", K_RUN, K_STALL);
    set_mem(5'd0, 1'b0, 1'b0);
    set_wb(5'd2, 1'b1);
    cyc("nofwd_wb", K_RUN, K_RUN);

    // Register 0 and unused sources never create a hazard.
    idle_inputs();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    set_mem(5'd0, 1'b1, 1'b0);
    cyc("r0_no_stall", K_RUN, K_RUN);
    set_id(5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ex(5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    set_mem(5'd0, 1'b0, 1'b0);
    cyc("unused_src", K_RUN, K_RUN);

    // Continuous load-use stall: the 4-bit counter on B saturates at 15.
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("sat%0d", i), K_STALL, K_STALL);
    end
    stall_clr = 1'b1;
    cyc("clr_wins", K_STALL, K_STALL);
    idle_inputs();
    cyc("after_clr", K_RUN, K_RUN);

    // Reset in the middle of a multiply aborts the freeze at once.
    ex_mul_start = 1'b1;
    cyc("rm_start", K_RUN, K_RUN);
    idle_inputs();
    cyc("rm_busy", K_MUL, K_MUL);
    rst = 1'b0;
    cyc("rm_reset", K_RESET, K_RESET);
    rst = 1'b1;
    cyc("rm_release", K_RUN, K_RUN);
    cyc("rm_idle", K_RUN, K_RUN);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
